// File: rtl/dpll_controller.sv
// dpll_controller: DPLL search FSM owning the assignment trail; drives find, BCP,
// chronological backtracking and the assignment memory, with optional cycle budget.
module dpll_controller #(
  parameter int NUM_VARIABLE = 128,
  parameter int VAR_IDX_W = $clog2(NUM_VARIABLE),
  parameter int MAX_CYCLES = 0,
  parameter bit DECIDE_POLARITY = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  output logic                 find_req,
  input  logic                 find_ack,
  input  logic                 find_valid,
  input  logic [VAR_IDX_W-1:0] find_var,
  output logic                 bcp_start,
  output logic [VAR_IDX_W-1:0] bcp_var,
  output logic                 bcp_val,
  input  logic                 imp_valid,
  input  logic [VAR_IDX_W-1:0] imp_var,
  input  logic                 imp_val,
  input  logic                 bcp_done,
  input  logic                 bcp_conflict,
  output logic                 asg_we,
  output logic [VAR_IDX_W-1:0] asg_var,
  output logic                 asg_val,
  output logic                 asg_clr,
  output logic                 asg_clear_all,
  output logic                 sat,
  output logic                 unsat,
  output logic                 abort,
  output logic                 busy,
  output logic [31:0]          decisions
);
  localparam int DW = $clog2(NUM_VARIABLE + 1);
  localparam logic [DW-1:0] FULL = DW'(NUM_VARIABLE);
  typedef enum logic [2:0] {IDLE, FIND, DECIDE, BCP, BACKTRACK, SAT, UNSAT, ABORT} state_t;
  state_t state, state_n;
  logic [DW-1:0] depth;
  logic [VAR_IDX_W-1:0] dec_var, top, wr;
  logic [VAR_IDX_W-1:0] tr_var [NUM_VARIABLE];
  logic tr_val [NUM_VARIABLE];
  logic tr_dec [NUM_VARIABLE];
  logic tr_flp [NUM_VARIABLE];
  logic issued, clr_q, conf, idle, overflow, push, flip, pop, conflict, hit;
  logic [31:0] cycles;
  assign top = VAR_IDX_W'(depth - 1'b1);
  assign wr = VAR_IDX_W'(depth);
  assign idle = state inside {IDLE, SAT, UNSAT, ABORT};
  assign busy = !idle;
  assign sat = state == SAT;
  assign unsat = state == UNSAT;
  assign abort = state == ABORT;
  assign asg_clear_all = clr_q;
  // the cycle after an accepted start is the memory-clear cycle; the find request follows it
  assign find_req = state == FIND && !issued && !clr_q;
  assign bcp_start = state == BCP && !issued;
  assign overflow = state == BCP && imp_valid && depth == FULL;
  assign push = state == DECIDE || (state == BCP && imp_valid && !overflow);
  assign flip = state == BACKTRACK && depth != '0 && tr_dec[top] && !tr_flp[top];
  assign pop = state == BACKTRACK && depth != '0 && !flip;
  assign conflict = bcp_conflict || conf || overflow;
  assign hit = MAX_CYCLES > 0 && busy && cycles == 32'(MAX_CYCLES - 1);
  assign asg_we = push || flip || pop;
  assign asg_clr = pop;
  assign asg_var = state == DECIDE ? dec_var : push ? imp_var : asg_we ? tr_var[top] : '0;
  assign asg_val = state == DECIDE ? DECIDE_POLARITY : push ? imp_val : flip && !tr_val[top];
  always_comb begin
    state_n = state;
    case (state)
      IDLE, SAT, UNSAT, ABORT: if (start) state_n = FIND;
      FIND: if (find_ack && !clr_q) state_n = find_valid ? DECIDE : SAT;
      DECIDE: state_n = BCP;
      BCP: if (bcp_done) state_n = conflict ? BACKTRACK : FIND;
      BACKTRACK: state_n = depth == '0 ? UNSAT : flip ? BCP : BACKTRACK;
    endcase
    if (hit) state_n = ABORT;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      depth <= '0;
      decisions <= '0;
      cycles <= '0;
      issued <= 1'b0;
      clr_q <= 1'b0;
      conf <= 1'b0;
      dec_var <= '0;
      bcp_var <= '0;
      bcp_val <= 1'b0;
    end else begin
      state <= state_n;
      issued <= state_n == state && (issued || find_req || bcp_start);
      clr_q <= idle && start;
      conf <= state == BCP && state_n == BCP && (conf || overflow);
      cycles <= idle ? (start ? '0 : cycles) : cycles + 1'b1;
      depth <= idle && start ? '0 : push ? depth + 1'b1 : pop ? depth - 1'b1 : depth;
      if (idle && start) decisions <= '0;
      else if (state == DECIDE && decisions != '1) decisions <= decisions + 1'b1;
      if (state == FIND && find_ack) dec_var <= find_var;
      if (state == DECIDE) {bcp_var, bcp_val} <= {dec_var, DECIDE_POLARITY};
      else if (flip) {bcp_var, bcp_val} <= {tr_var[top], !tr_val[top]};
    end
  always_ff @(posedge clock)
    if (push) begin
      tr_var[wr] <= asg_var;
      tr_val[wr] <= asg_val;
      tr_dec[wr] <= state == DECIDE;
      tr_flp[wr] <= 1'b0;
    end else if (flip) begin
      tr_val[top] <= !tr_val[top];
      tr_flp[top] <= 1'b1;
    end
endmodule

// File: tb/tb_dpll_controller.sv
// tb_dpll_controller: directed solves against a queue-based reference model compared every cycle,
// plus hand-computed write sequences and latencies.
module tb_dpll_controller;
  localparam int N = 4;
  localparam int VW = 2;
  localparam int MAXC = 20;
  localparam bit POL = 1'b0;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic find_req, find_ack = 1'b0, find_valid = 1'b0;
  logic [VW-1:0] find_var = '0;
  logic bcp_start, bcp_val;
  logic [VW-1:0] bcp_var;
  logic imp_valid = 1'b0, imp_val = 1'b0, bcp_done = 1'b0, bcp_conflict = 1'b0;
  logic [VW-1:0] imp_var = '0;
  logic asg_we, asg_val, asg_clr, asg_clear_all, sat, unsat, abort, busy;
  logic [VW-1:0] asg_var;
  logic [31:0] decisions;
  int checks = 0, errors = 0, busy_seen = 0;
  logic [VW+1:0] wlog[$];

  dpll_controller #(.NUM_VARIABLE(N), .MAX_CYCLES(MAXC), .DECIDE_POLARITY(POL)) dut (
    .clock(clock), .reset(reset), .start(start),
    .find_req(find_req), .find_ack(find_ack), .find_valid(find_valid), .find_var(find_var),
    .bcp_start(bcp_start), .bcp_var(bcp_var), .bcp_val(bcp_val),
    .imp_valid(imp_valid), .imp_var(imp_var), .imp_val(imp_val),
    .bcp_done(bcp_done), .bcp_conflict(bcp_conflict),
    .asg_we(asg_we), .asg_var(asg_var), .asg_val(asg_val), .asg_clr(asg_clr),
    .asg_clear_all(asg_clear_all), .sat(sat), .unsat(unsat), .abort(abort),
    .busy(busy), .decisions(decisions)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] packed_log();
    logic [63:0] r;
    r = '0;
    foreach (wlog[i]) r = (r << 4) | 64'(wlog[i]);
    return r;
  endfunction

  // reference model: trail as a queue of literals, solve phase as a named mode
  typedef struct packed {logic [VW-1:0] v; logic val; logic dec; logic flp;} ent_t;
  typedef enum int {M_IDLE, M_FIND, M_DECIDE, M_BCP, M_BT, M_SAT, M_UNSAT, M_ABORT} mode_t;
  mode_t m = M_IDLE;
  ent_t tr[$];
  bit m_clear = 0, m_sent = 0, m_conf = 0;
  int m_busy_n = 0;
  int unsigned m_dec = 0;
  logic [VW-1:0] m_pend = '0, m_lv = '0;
  logic m_lval = 1'b0;

  always @(negedge clock) begin : model
    ent_t t;
    logic fr, bs, we, cl, vl, bz, can_flip, nclear;
    logic [VW-1:0] vr;
    if (busy === 1'b1) busy_seen++;
    if (asg_we === 1'b1) wlog.push_back({asg_var, asg_val & !asg_clr, asg_clr});
    if (reset) begin
      chk("reset_outs", {find_req, bcp_start, asg_we, asg_clr, asg_clear_all, sat, unsat, abort, busy}, '0);
      m = M_IDLE; tr.delete(); m_clear = 0; m_sent = 0; m_conf = 0; m_busy_n = 0; m_dec = 0;
    end else begin
      bz = m inside {M_FIND, M_DECIDE, M_BCP, M_BT};
      fr = m == M_FIND && !m_sent && !m_clear;
      bs = m == M_BCP && !m_sent;
      we = 0; cl = 0; vl = 0; vr = '0; t = '0; can_flip = 0;
      if (m == M_DECIDE) begin we = 1; vr = m_pend; vl = POL; end
      else if (m == M_BCP && imp_valid && tr.size() < N) begin we = 1; vr = imp_var; vl = imp_val; end
      else if (m == M_BT && tr.size() > 0) begin
        t = tr[$]; can_flip = t.dec && !t.flp; we = 1; vr = t.v; vl = !t.val; cl = !can_flip;
      end
      chk("ctl", {find_req, bcp_start, asg_clear_all, asg_we, asg_clr, sat, unsat, abort, busy},
          {fr, bs, m_clear, we, cl, m == M_SAT, m == M_UNSAT, m == M_ABORT, bz});
      if (we) chk("asg_var", asg_var, vr);
      if (we && !cl) chk("asg_val", asg_val, vl);
      if (m == M_BCP) chk("bcp_lit", {bcp_var, bcp_val}, {m_lv, m_lval});
      chk("decisions", decisions, m_dec);
      nclear = !bz && start;
      if (nclear) begin
        m = M_FIND; tr.delete(); m_dec = 0; m_busy_n = 0; m_sent = 0;
      end else if (m == M_FIND) begin
        if (fr) m_sent = 1;
        if (find_ack && !m_clear) begin
          m = find_valid ? M_DECIDE : M_SAT; m_pend = find_var; m_sent = 0;
        end
      end else if (m == M_DECIDE) begin
        tr.push_back('{v: m_pend, val: POL, dec: 1'b1, flp: 1'b0});
        m_dec++; m_lv = m_pend; m_lval = POL;
        m = M_BCP; m_sent = 0; m_conf = 0;
      end else if (m == M_BCP) begin
        if (bs) m_sent = 1;
        if (imp_valid) begin
          if (tr.size() < N) tr.push_back('{v: imp_var, val: imp_val, dec: 1'b0, flp: 1'b0});
          else m_conf = 1;
        end
        if (bcp_done) begin m = (bcp_conflict || m_conf) ? M_BT : M_FIND; m_sent = 0; m_conf = 0; end
      end else if (m == M_BT) begin
        if (tr.size() == 0) m = M_UNSAT;
        else if (can_flip) begin
          void'(tr.pop_back()); t.val = !t.val; t.flp = 1; tr.push_back(t);
          m_lv = t.v; m_lval = t.val; m = M_BCP; m_sent = 0; m_conf = 0;
        end else void'(tr.pop_back());
      end
      if (bz) begin
        m_busy_n++;
        if (MAXC > 0 && m_busy_n == MAXC) m = M_ABORT;
      end
      m_clear = nclear;
    end
  end

  task automatic tick(); @(posedge clock); #1; endtask
  task automatic pulse_start(); start = 1; tick(); start = 0; endtask
  task automatic await_find(output int n);
    n = 0;
    while (!find_req && n < 40) begin tick(); n++; end
    chk("find_req_seen", find_req, 1'b1);
  endtask
  task automatic await_bcp(output int n);
    n = 0;
    while (!bcp_start && n < 40) begin tick(); n++; end
    chk("bcp_start_seen", bcp_start, 1'b1);
  endtask
  task automatic await_idle(output int n);
    n = 0;
    while (busy && n < 60) begin tick(); n++; end
    chk("idle_reached", busy, 1'b0);
  endtask
  task automatic answer_find(input logic valid, input logic [VW-1:0] v);
    find_ack = 1; find_valid = valid; find_var = v; tick(); find_ack = 0; find_valid = 0;
  endtask
  task automatic imp(input logic [VW-1:0] v, input logic val, input logic done, input logic conf);
    imp_valid = 1; imp_var = v; imp_val = val; bcp_done = done; bcp_conflict = conf;
    tick();
    imp_valid = 0; bcp_done = 0; bcp_conflict = 0;
  endtask
  task automatic done(input logic conf);
    bcp_done = 1; bcp_conflict = conf; tick(); bcp_done = 0; bcp_conflict = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) tick();
    chk("reset_decisions", decisions, 32'd0);
    reset = 0; tick();
    // immediate SAT
    wlog.delete(); pulse_start();
    chk("t1_clear_pulse", asg_clear_all, 1'b1);
    await_find(n); chk("t1_start_to_find", n + 1, 2);
    answer_find(1'b0, 2'd0);
    chk("t1_flags", {sat, unsat, abort, busy}, 4'b1000);
    chk("t1_decisions", decisions, 32'd0);
    // one decision, two implications, then SAT
    wlog.delete(); pulse_start(); await_find(n); answer_find(1'b1, 2'd2);
    chk("t2_decide_write", {asg_we, asg_clr, asg_var, asg_val}, {1'b1, 1'b0, 2'd2, 1'b0});
    tick();
    chk("t2_bcp_start", {bcp_start, bcp_var, bcp_val}, {1'b1, 2'd2, 1'b0});
    imp(2'd3, 1'b1, 1'b0, 1'b0); imp(2'd0, 1'b0, 1'b1, 1'b0);
    await_find(n); chk("t2_done_to_find", n, 0);
    answer_find(1'b0, 2'd0);
    chk("t2_sat", sat, 1'b1);
    chk("t2_log_len", wlog.size(), 3);
    chk("t2_log", packed_log(), 64'h8E0);
    // both polarities of var 1 conflict
    wlog.delete(); pulse_start(); await_find(n); answer_find(1'b1, 2'd1); tick();
    done(1'b1);
    chk("t3_flip_write", {asg_we, asg_clr, asg_var, asg_val}, {1'b1, 1'b0, 2'd1, 1'b1});
    tick();
    chk("t3_bcp_flipped", {bcp_start, bcp_var, bcp_val}, {1'b1, 2'd1, 1'b1});
    done(1'b1); tick(); tick();
    chk("t3_flags", {sat, unsat, abort, busy}, 4'b0100);
    chk("t3_decisions", decisions, 32'd1);
    chk("t3_log_len", wlog.size(), 3);
    chk("t3_log", packed_log(), 64'h465);
    // two decisions, conflict backtracks over one implication
    wlog.delete(); pulse_start(); await_find(n); answer_find(1'b1, 2'd0); tick();
    imp(2'd2, 1'b1, 1'b1, 1'b0);
    await_find(n); answer_find(1'b1, 2'd1); tick();
    imp(2'd3, 1'b0, 1'b0, 1'b0); done(1'b1);
    chk("t4_bt_clr", {asg_we, asg_clr, asg_var}, {1'b1, 1'b1, 2'd3});
    tick();
    chk("t4_bt_flip", {asg_we, asg_clr, asg_var, asg_val}, {1'b1, 1'b0, 2'd1, 1'b1});
    tick();
    chk("t4_bcp_after_bt", {bcp_start, bcp_var, bcp_val}, {1'b1, 2'd1, 1'b1});
    done(1'b0); await_find(n); answer_find(1'b0, 2'd0);
    chk("t4_sat", sat, 1'b1);
    chk("t4_decisions", decisions, 32'd2);
    chk("t4_log_len", wlog.size(), 6);
    chk("t4_log", packed_log(), 64'h0A4CD6);
    // trail overflow forces a conflict
    wlog.delete(); pulse_start(); await_find(n); answer_find(1'b1, 2'd0); tick();
    imp(2'd1, 1'b1, 1'b0, 1'b0); imp(2'd2, 1'b1, 1'b0, 1'b0); imp(2'd3, 1'b1, 1'b0, 1'b0);
    imp_valid = 1; imp_var = 2'd1; imp_val = 1'b0; #1;
    chk("t5_ovf_no_write", asg_we, 1'b0);
    tick(); imp_valid = 0;
    imp(2'd2, 1'b0, 1'b0, 1'b0); done(1'b0);
    chk("t5_forced_bt", {asg_we, asg_clr, asg_var}, {1'b1, 1'b1, 2'd3});
    await_bcp(n); chk("t5_bt_to_bcp", n, 4);
    done(1'b1); await_idle(n);
    chk("t5_flags", {sat, unsat, abort, busy}, 4'b0100);
    chk("t5_log_len", wlog.size(), 9);
    chk("t5_log", packed_log(), 64'h06AED9521);
    // cycle budget expires inside a BCP that never finishes; start while busy is ignored
    busy_seen = 0; pulse_start(); await_find(n); answer_find(1'b1, 2'd0); tick();
    start = 1; tick(); start = 0;
    await_idle(n);
    chk("t6_busy_cycles", busy_seen, 20);
    chk("t6_flags", {sat, unsat, abort, busy}, 4'b0010);
    pulse_start();
    chk("t6_restart", {asg_clear_all, abort, busy}, 3'b101);
    // reset mid-solve
    await_find(n); answer_find(1'b1, 2'd2); tick();
    reset = 1; #1;
    chk("t7_reset_mid", {busy, asg_clear_all, asg_we, bcp_start}, 4'b0000);
    tick();
    chk("t7_no_clear_all", asg_clear_all, 1'b0);
    reset = 0; tick();
    chk("t7_after_reset", {busy, asg_clear_all, sat, unsat, abort}, 5'b00000);
    chk("t7_decisions", decisions, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dpll_controller.md
# dpll_controller

Parametrised DPLL search controller for the SAT accelerator: owns the top-level solve state machine and an on-chip assignment trail, and drives decisions, BCP runs and chronological backtracking. Sits between the variable-selection unit (find port), the BCP engine (bcp/imp ports) and the assignment memory (asg port). Adds over the previous controller: full trail stack, decision flipping, restart on `start`, a configurable cycle budget with abort, and selectable decision polarity.

## Interface
- NUM_VARIABLE, 128, number of variables; also trail depth.
- VAR_IDX_W, $clog2(NUM_VARIABLE) (7), variable index width.
- MAX_CYCLES, 0, solve cycle budget; 0 disables the timeout.
- DECIDE_POLARITY, 0, value given to a fresh decision (0 or 1).

- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears everything listed under reset values.
- start  in  1  one-cycle pulse; begins a solve (accepted in IDLE, SAT, UNSAT, ABORT only).
- find_req  out  1  one-cycle pulse requesting next unassigned variable.
- find_ack  in  1  one-cycle response strobe.
- find_valid  in  1  with find_ack: 1 = find_var valid, 0 = all variables assigned.
- find_var  in  VAR_IDX_W  selected variable.
- bcp_start  out  1  one-cycle pulse launching BCP on bcp_var/bcp_val.
- bcp_var  out  VAR_IDX_W  literal variable, held stable until bcp_done.
- bcp_val  out  1  literal value.
- imp_valid  in  1  implied assignment strobe during BCP.
- imp_var  in  VAR_IDX_W; imp_val  in  1  implied literal.
- bcp_done  in  1  BCP finished strobe; bcp_conflict  in  1  qualifies it.
- asg_we  out  1  assignment memory write; asg_var out VAR_IDX_W; asg_val out 1; asg_clr out 1 (with asg_we: mark unassigned).
- asg_clear_all  out  1  one-cycle pulse clearing the whole assignment memory.
- sat, unsat, abort  out  1  sticky result flags.
- busy  out  1  high in every state except IDLE/SAT/UNSAT/ABORT.
- decisions  out  32  decision counter (saturating).

## Operation
- Trail: NUM_VARIABLE entries {var, val, is_dec, flipped}; pointer `depth` 0..NUM_VARIABLE.
- States: IDLE, FIND, DECIDE, BCP, BACKTRACK, SAT, UNSAT, ABORT.
- IDLE/SAT/UNSAT/ABORT + start: clear flags, depth=0, decisions=0, cycle count=0, pulse asg_clear_all -> FIND.
- FIND: pulse find_req on entry, wait find_ack. find_valid=0 -> SAT. find_valid=1 -> DECIDE with latched var.
- DECIDE (1 cycle): push {var, DECIDE_POLARITY, 1, 0}; asg_we=1, asg_val=DECIDE_POLARITY; decisions+1; -> BCP.
- BCP: pulse bcp_start on entry. Each imp_valid cycle: push {imp_var, imp_val, 0, 0}, asg_we same cycle. imp_valid with depth==NUM_VARIABLE: ignore push, force conflict. bcp_done & !conflict -> FIND; bcp_done & conflict -> BACKTRACK. imp_valid and bcp_done same cycle: implication recorded first, then transition.
- BACKTRACK, one entry per cycle on top (depth-1): depth==0 -> UNSAT. Top is_dec & !flipped: rewrite val=~val, flipped=1, asg_we with new val, bcp_var/val = that literal -> BCP. Otherwise: asg_we=1 asg_clr=1 for top var, depth-1, stay.
- Timeout: MAX_CYCLES>0 and busy cycle count reaches MAX_CYCLES -> ABORT from any busy state; pending BCP result discarded.
- sat/unsat/abort mutually exclusive, held until next accepted start or reset. start ignored while busy.

## Timing
- Reset values: state IDLE, all outputs 0, depth 0, counters 0.
- start -> find_req: 2 cycles (clear cycle, FIND entry).
- find_ack -> DECIDE next cycle; DECIDE -> bcp_start next cycle (asg write precedes bcp_start by 1 cycle).
- bcp_done -> find_req or first BACKTRACK cycle: 1 cycle.
- Backtrack over k entries to a flippable decision: k+1 cycles to bcp_start.
- Final-state flag asserts the cycle after the deciding event (find_ack, depth==0 check, budget hit).
- Reset mid-solve: immediate return to IDLE, no asg_clear_all emitted.

## Test plan
- Reset then start, find returns valid=0 on first ack -> sat=1 after 3 cycles, decisions=0, unsat=abort=0.
- NUM_VARIABLE=4, single decision var 2, BCP implies (3,1),(0,0), no conflict, then find valid=0 -> asg writes (2,0),(3,1),(0,0) in order, sat=1, depth=3.
- Decision var 1 conflicts at val 0 and val 1 -> flip write (1,1) then clr of var 1, unsat=1, decisions=1.
- Two decisions (var0, var1) with one implication each, conflict -> clr implied var, flip var1 to 1, bcp_start bcp_var=1 bcp_val=1 after 2 BACKTRACK cycles.
- MAX_CYCLES=20, BCP never done -> abort=1 exactly at busy cycle 20, busy=0; start -> asg_clear_all pulse, abort=0.
- Overflow: NUM_VARIABLE=2, imp_valid 3 times in one BCP -> forced conflict, BACKTRACK entered after bcp_done.
